// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_pkg
//  Brief    : Shared types and constants for the UART command frame controller.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    localparam logic [2:0] c_err_none    = 3'd0;
    localparam logic [2:0] c_err_badlen  = 3'd1;
    localparam logic [2:0] c_err_chksum  = 3'd2;
    localparam logic [2:0] c_err_gap     = 3'd3;
    localparam logic [2:0] c_err_overrun = 3'd4;

    localparam logic [7:0] c_sync_byte_default = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_buf.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_buf
//  Brief    : Payload register array, one write port and one async read port.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem_q [DEPTH];

    // Decoded per-entry compare keeps out-of-range addresses harmless.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i_we && (i_waddr == AW'(i))) begin
                mem_q[i] <= i_wdata;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i_raddr == AW'(i)) begin
                o_rdata = mem_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_frame_ctrl
//  Brief    : Parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte stream and
//             commits verified payloads to a register bus.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_frame_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [7:0]  SYNC_BYTE = c_sync_byte_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_endofpacket,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [2:0] err_code
);

    localparam int unsigned c_idx_w = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  c_max_len = 8'(MAX_LEN);
    localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

    state_e             state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [c_idx_w-1:0] len_q, len_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic               wr_en_q, wr_en_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               pkt_done_q, pkt_done_d;
    logic               pkt_err_q, pkt_err_d;
    logic [2:0]         err_code_q, err_code_d;

    logic [c_idx_w-1:0] w_idx_inc;
    logic [7:0]         w_sum_next;
    logic               w_buf_we;
    logic [c_idx_w-1:0] w_buf_raddr;
    logic [7:0]         w_buf_rdata;

    assign w_idx_inc   = idx_q + c_idx_one;
    assign w_sum_next  = sum_q + rx_data;
    // During commit the read port looks one entry ahead so the next write
    // word is ready on the cycle its predecessor is acknowledged.
    assign w_buf_raddr = (state_q == ST_COMMIT) ? w_idx_inc : '0;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (c_idx_w)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (idx_q),
        .i_wdata (rx_data),
        .i_raddr (w_buf_raddr),
        .o_rdata (w_buf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pkt_done_d = 1'b0;
        pkt_err_d  = 1'b0;
        err_code_d = err_code_q;
        w_buf_we   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    sum_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_ready) begin
                    addr_d  = rx_data;
                    sum_d   = w_sum_next;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_ready) begin
                    if ((rx_data == 8'd0) || (rx_data > c_max_len)) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = c_err_badlen;
                        state_d    = ST_IDLE;
                    end else begin
                        len_d   = c_idx_w'(rx_data);
                        idx_d   = '0;
                        sum_d   = w_sum_next;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_ready) begin
                    w_buf_we = 1'b1;
                    sum_d    = w_sum_next;
                    idx_d    = w_idx_inc;
                    if (w_idx_inc == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_ready) begin
                    if (w_sum_next == 8'd0) begin
                        idx_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = w_buf_rdata;
                        state_d   = ST_COMMIT;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = c_err_chksum;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                if (rx_ready) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = c_err_overrun;
                end
                if (wr_ack) begin
                    if (w_idx_inc == len_q) begin
                        wr_en_d    = 1'b0;
                        pkt_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d     = w_idx_inc;
                        wr_addr_d = wr_addr_q + 8'd1;
                        wr_data_d = w_buf_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte arriving with the gap strobe wins; the gap is ignored then.
        if (!rx_ready && rx_endofpacket &&
            (state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK})) begin
            pkt_err_d  = 1'b1;
            err_code_d = c_err_gap;
            state_d    = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_code_q <= c_err_none;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            pkt_done_q <= pkt_done_d;
            pkt_err_q  <= pkt_err_d;
            err_code_q <= err_code_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign pkt_done = pkt_done_q;
    assign pkt_err  = pkt_err_q;
    assign err_code = err_code_q;

endmodule
`default_nettype wire
